song_sequencer: RTL and testbench

//  Autonomous melody player feeding the note datapath: walks a fixed 16-entry

---
 rtl/song_sequencer.sv | 178 +++++++++++++++++
 tb/tb_song_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Autonomous 16-entry melody player: holds each ROM note for beats*TICKS_PER_BEAT cycles, then GAP_TICKS of silence.
// All outputs registered; first note appears one edge after start is sampled. No backpressure: stop aborts immediately.
module song_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 25_000_000,
    parameter int unsigned GAP_TICKS      = 1_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [11:0] freq,
    output logic        note_on,
    output logic        busy,
    output logic [3:0]  step,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] hz;
        logic [2:0]  beats;
    } rom_entry_t;

    localparam bit             HAS_GAP  = (GAP_TICKS > 0);
    localparam logic [CNT_W-1:0] GAP_LOAD = HAS_GAP ? CNT_W'(GAP_TICKS - 1) : '0;

    function automatic rom_entry_t rom_lookup(input logic [3:0] idx);
        rom_entry_t e;
        case (idx)
            4'd0:    e = '{hz: 12'd261, beats: 3'd1};
            4'd1:    e = '{hz: 12'd293, beats: 3'd1};
            4'd2:    e = '{hz: 12'd330, beats: 3'd1};
            4'd3:    e = '{hz: 12'd349, beats: 3'd1};
            4'd4:    e = '{hz: 12'd392, beats: 3'd1};
            4'd5:    e = '{hz: 12'd440, beats: 3'd1};
            4'd6:    e = '{hz: 12'd494, beats: 3'd1};
            4'd7:    e = '{hz: 12'd0,   beats: 3'd1};
            4'd8:    e = '{hz: 12'd494, beats: 3'd1};
            4'd9:    e = '{hz: 12'd440, beats: 3'd1};
            4'd10:   e = '{hz: 12'd392, beats: 3'd1};
            4'd11:   e = '{hz: 12'd349, beats: 3'd1};
            4'd12:   e = '{hz: 12'd330, beats: 3'd1};
            4'd13:   e = '{hz: 12'd293, beats: 3'd1};
            4'd14:   e = '{hz: 12'd261, beats: 3'd2};
            default: e = '{hz: 12'd0,   beats: 3'd2};
        endcase
        return e;
    endfunction

    // Counter is loaded with duration-1 so it reads 0 on the note's final cycle.
    function automatic logic [CNT_W-1:0] note_len(input logic [2:0] beats);
        logic [CNT_W-1:0] b;
        b = (beats == 3'd0) ? CNT_W'(1) : CNT_W'(beats);
        return b * CNT_W'(TICKS_PER_BEAT) - CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic [11:0]      freq_q, freq_d;
    logic             note_on_q, note_on_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             advance;
    logic             load;
    logic [3:0]       load_idx;
    rom_entry_t       load_ent;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        freq_d   = freq_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        load_idx = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    load_idx = 4'd0;
                end
            end
            PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    freq_d  = 12'd0;
                end else begin
                    advance = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // loop_en only matters at the wrap point after entry 15.
        if (advance) begin
            if (step_q != 4'd15) begin
                load     = 1'b1;
                load_idx = step_q + 4'd1;
            end else if (loop_en) begin
                load     = 1'b1;
                load_idx = 4'd0;
            end else begin
                state_d = IDLE;
                step_d  = 4'd0;
                freq_d  = 12'd0;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
        end

        load_ent = rom_lookup(load_idx);
        if (load) begin
            state_d = PLAY;
            step_d  = load_idx;
            freq_d  = load_ent.hz;
            cnt_d   = note_len(load_ent.beats);
        end

        if (stop) begin
            state_d = IDLE;
            step_d  = 4'd0;
            freq_d  = 12'd0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        busy_d    = (state_d != IDLE);
        note_on_d = (state_d == PLAY) && (freq_d != 12'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            step_q    <= 4'd0;
            freq_q    <= 12'd0;
            note_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            freq_q    <= freq_d;
            note_on_q <= note_on_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign freq    = freq_q;
    assign note_on = note_on_q;
    assign busy    = busy_q;
    assign step    = step_q;
    assign done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two builds (gap=2, gap=0) checked every cycle against a timeline model,
// plus directed literal checks of note timing, rests, looping, stop, ignored start and mid-song reset.
module tb_song_sequencer;

    localparam int TPB = 4;

    logic clk = 1'b0;
    logic rst, start, stop, loop_en;

    logic [11:0] freq_a, freq_b;
    logic        note_on_a, note_on_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]  step_a, step_b;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  chk_en    = 1'b0;

    int rom_f [16] = '{261, 293, 330, 349, 392, 440, 494, 0, 494, 440, 392, 349, 330, 293, 261, 0};
    int rom_b [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};

    song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .freq(freq_a), .note_on(note_on_a), .busy(busy_a), .step(step_a), .done(done_a)
    );

    song_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .freq(freq_b), .note_on(note_on_b), .busy(busy_b), .step(step_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- timeline model ----------------
    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int song_len(input int i);
        int sum;
        sum = 0;
        for (int e = 0; e < 16; e++) sum += ((rom_b[e] == 0) ? 1 : rom_b[e]) * TPB + gap_of(i);
        return sum;
    endfunction

    // Position in the song (cycles since first note edge) -> expected freq and step.
    function automatic void expect_at(input int i, input int pos, output int f, output int s);
        int p, d, g;
        p = pos;
        g = gap_of(i);
        f = 0;
        s = 0;
        for (int e = 0; e < 16; e++) begin
            d = ((rom_b[e] == 0) ? 1 : rom_b[e]) * TPB;
            if (p >= 0 && p < d) begin
                f = rom_f[e];
                s = e;
                p = -1000000;
            end else if (p >= 0) begin
                p -= d;
                if (p < g) begin
                    f = 0;
                    s = e;
                    p = -1000000;
                end else begin
                    p -= g;
                end
            end
        end
    endfunction

    bit m_play [2] = '{1'b0, 1'b0};
    int m_pos  [2] = '{0, 0};
    bit m_done [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (rst || stop) begin
                m_play[i] <= 1'b0;
            end else if (!m_play[i]) begin
                if (start) begin
                    m_play[i] <= 1'b1;
                    m_pos[i]  <= 0;
                end
            end else if (m_pos[i] + 1 == song_len(i)) begin
                m_pos[i] <= 0;
                if (!loop_en) begin
                    m_play[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                end
            end else begin
                m_pos[i] <= m_pos[i] + 1;
            end
        end
    end

    task automatic check_dut(input string tag, input int i, input int fq, input int no,
                             input int bz, input int st, input int dn);
        int f, s;
        if (m_play[i]) begin
            expect_at(i, m_pos[i], f, s);
            check({tag, ".freq"}, fq, f);
            check({tag, ".note_on"}, no, (f != 0) ? 1 : 0);
            check({tag, ".busy"}, bz, 1);
            check({tag, ".step"}, st, s);
            check({tag, ".done"}, dn, 0);
        end else begin
            check({tag, ".freq"}, fq, 0);
            check({tag, ".note_on"}, no, 0);
            check({tag, ".busy"}, bz, 0);
            check({tag, ".step"}, st, 0);
            check({tag, ".done"}, dn, m_done[i] ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("gap2", 0, int'(freq_a), int'(note_on_a), int'(busy_a), int'(step_a), int'(done_a));
            check_dut("gap0", 1, int'(freq_b), int'(note_on_b), int'(busy_b), int'(step_b), int'(done_b));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, dcount, b_done_at;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;

        // reset held three cycles
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst freq", int'(freq_a), 0);
        check("rst busy", int'(busy_a), 0);
        check("rst step", int'(step_a), 0);
        check("rst done", int'(done_a), 0);
        check("rst note_on", int'(note_on_a), 0);
        rst = 1'b0;
        tick();

        // full song, no loop
        start = 1'b1;
        tick();
        start = 1'b0;
        check("song first freq", int'(freq_a), 261);
        n = 0;
        b_done_at = -1;
        while (!done_a && n < 200) begin
            tick();
            n++;
            if (done_b) b_done_at = n;
            if (n == 3) check("note0 last cycle", int'(freq_a), 261);
            if (n == 4) check("gap after note0", int'(freq_a), 0);
            if (n == 4) check("gap0 back-to-back", int'(freq_b), 293);
            if (n == 6) check("note1 freq", int'(freq_a), 293);
            if (n == 42) check("rest freq", int'(freq_a), 0);
            if (n == 42) check("rest note_on", int'(note_on_a), 0);
            if (n == 45) check("rest busy", int'(busy_a), 1);
            if (n == 42) check("rest step", int'(step_a), 7);
            if (n == 84) check("step14 start", int'(freq_a), 261);
            if (n == 91) check("step14 hold 8", int'(freq_a), 261);
            if (n == 92) check("step14 gap", int'(freq_a), 0);
        end
        check("done latency", n, 104);
        check("busy falls with done", int'(busy_a), 0);
        check("gap0 done latency", b_done_at, 72);
        tick();
        check("done one cycle", int'(done_a), 0);

        // looping: three passes, no done
        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 3 * 104 + 10; k++) begin
            tick();
            if (done_a || done_b) dcount++;
            if (k == 104) check("loop wrap freq", int'(freq_a), 261);
            if (k == 103) check("loop last gap step", int'(step_a), 15);
        end
        check("loop no done", dcount, 0);
        check("loop still busy", int'(busy_a), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        check("stop idle busy", int'(busy_a), 0);
        check("stop idle freq", int'(freq_a), 0);
        tick();

        // stop coincident with start during step 3
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) tick();
        check("pre-stop step", int'(step_a), 3);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("stop+start busy", int'(busy_a), 0);
        check("stop+start freq", int'(freq_a), 0);
        check("stop+start step", int'(step_a), 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("replay freq", int'(freq_a), 261);

        // start ignored at step 5, reset at step 9
        for (int k = 1; k <= 55; k++) begin
            tick();
            start = (k == 31);
            if (k == 32) check("ignored start step", int'(step_a), 5);
            if (k == 32) check("ignored start freq", int'(freq_a), 440);
            if (k == 55) check("pre-rst step", int'(step_a), 9);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midsong rst busy", int'(busy_a), 0);
        check("midsong rst freq", int'(freq_a), 0);
        check("midsong rst done", int'(done_a), 0);

        // clean full run after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 110; k++) begin
            tick();
            if (done_a) dcount++;
        end
        check("post-rst done count", dcount, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
